flash_reader_arb: RTL and testbench

- Shares one quad-I/O flash line reader (24-bit line address in, 1-cycle rd pulse, 1-cycle done pulse, LINE_SIZE-bit line out) between two requesters, e.g. the cache controller (port 0) and a data/boot-copy port (port 1).
- Latches requests and arbitrates round-robin (or fixed priority), so the reader never sees rd while busy.
- Issues exactly one fetch at a time and routes done/line back to the owner.

---
 rtl/flash_arb_pkg.sv | 27 ++
 rtl/flash_reader_arb_line_buf.sv | 45 ++++
 rtl/flash_reader_arb.sv | 135 +++++++++++++
 tb/tb_flash_reader_arb.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_arb_pkg.sv
// Shared types and helpers for the two-port flash line reader arbiter.
// Line geometry defaults to a 128-bit line; modules derive their own offset from LINE_SIZE.
package flash_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10
    } arb_state_e;

    localparam int unsigned DEF_LINE_SIZE = 128;
    localparam int unsigned LINE_BYTES    = DEF_LINE_SIZE / 8;
    localparam int unsigned OFFSET_W      = $clog2(LINE_BYTES);
    localparam int unsigned MAX_ADDR_W    = 32;

    function automatic int unsigned offset_w(input int unsigned line_size);
        return $clog2(line_size / 8);
    endfunction

    function automatic logic [MAX_ADDR_W-1:0] line_align(input logic [MAX_ADDR_W-1:0] addr,
                                                         input int unsigned off_w = OFFSET_W);
        logic [MAX_ADDR_W-1:0] mask;
        mask = '1 << off_w;
        return addr & mask;
    endfunction

endpackage

// File: rtl/flash_reader_arb_line_buf.sv
// One-entry buffer of the last fetched flash line (tag, data, valid) with tag compare.
// Only instantiated when FLASH_ARB_LINE_BUF_EN is defined.
module flash_arb_line_buf
    import flash_arb_pkg::*;
#(
    parameter int unsigned LINE_SIZE = 128,
    parameter int unsigned TAG_W     = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr,
    input  logic                 inv,
    input  logic [TAG_W-1:0]     wr_tag,
    input  logic [LINE_SIZE-1:0] wr_line,
    input  logic [TAG_W-1:0]     lookup_tag,
    output logic                 hit,
    output logic [LINE_SIZE-1:0] rd_line
);

    logic                 valid;
    logic [TAG_W-1:0]     tag;
    logic [LINE_SIZE-1:0] data;

    // Invalidate takes precedence over a simultaneous write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
        end else if (inv) begin
            valid <= 1'b0;
        end else if (wr) begin
            valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            tag  <= wr_tag;
            data <= wr_line;
        end
    end

    assign hit     = valid && (tag == lookup_tag);
    assign rd_line = data;

endmodule

// File: rtl/flash_reader_arb.sv
// Two-port arbiter in front of a single quad-I/O flash line reader; one fetch in flight.
// Optional one-entry line buffer enabled by defining FLASH_ARB_LINE_BUF_EN.
module flash_reader_arb
    import flash_arb_pkg::*;
#(
    parameter int unsigned LINE_SIZE  = 128,
    parameter int unsigned ADDR_WIDTH = 24,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd0,
    input  logic                  rd1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic                  done0,
    output logic                  done1,
    output logic [LINE_SIZE-1:0]  line,
    output logic                  busy,
    output logic                  drop,
    input  logic                  buf_inv,
    output logic [ADDR_WIDTH-1:0] fr_addr,
    output logic                  fr_rd,
    input  logic                  fr_done,
    input  logic [LINE_SIZE-1:0]  fr_line
);

    localparam int unsigned LINE_OFF_W = offset_w(LINE_SIZE);

    arb_state_e            state, state_nxt;
    logic [1:0]            pend, pend_nxt;
    logic [1:0]            rd_vec, done_vec, drop_vec, accept;
    logic [ADDR_WIDTH-1:0] padd0, padd1, padd_sel;
    logic                  last_grant, g_sel;
    logic                  req_any, hit_now, fetch_now, fr_complete;
    logic                  buf_hit;
    logic [LINE_SIZE-1:0]  buf_line;

    assign rd_vec = {rd1, rd0};

`ifdef FLASH_ARB_LINE_BUF_EN
    flash_arb_line_buf #(
        .LINE_SIZE (LINE_SIZE),
        .TAG_W     (ADDR_WIDTH - LINE_OFF_W)
    ) u_line_buf (
        .clk        (clk),
        .rst        (rst),
        .wr         (fr_complete),
        .inv        (buf_inv),
        .wr_tag     (fr_addr[ADDR_WIDTH-1:LINE_OFF_W]),
        .wr_line    (fr_line),
        .lookup_tag (padd_sel[ADDR_WIDTH-1:LINE_OFF_W]),
        .hit        (buf_hit),
        .rd_line    (buf_line)
    );
`else
    logic unused_buf_inv;
    assign unused_buf_inv = buf_inv;
    assign buf_hit        = 1'b0;
    assign buf_line       = '0;
`endif

    always_comb begin
        state_nxt = state;
        req_any   = |pend;
        // With both pending, round-robin hands the grant to the port that did not win last.
        if (pend == 2'b11) begin
            g_sel = FIXED_PRIO ? 1'b0 : ~last_grant;
        end else begin
            g_sel = pend[1] & ~pend[0];
        end
        padd_sel    = g_sel ? padd1 : padd0;
        hit_now     = (state == ST_IDLE) && req_any && buf_hit;
        fetch_now   = (state == ST_IDLE) && req_any && !buf_hit;
        fr_complete = (state == ST_WAIT) && fr_done;

        done_vec[0] = (fr_complete && !last_grant) || (hit_now && !g_sel);
        done_vec[1] = (fr_complete &&  last_grant) || (hit_now &&  g_sel);

        if (hit_now) begin
            line = buf_line;
        end else if (fr_complete) begin
            line = fr_line;
        end else begin
            line = '0;
        end

        busy = (state != ST_IDLE);
        for (int n = 0; n < 2; n++) begin
            drop_vec[n] = rd_vec[n] &&
                          ((busy && (last_grant == n[0]) && !done_vec[n]) ||
                           (fetch_now && (g_sel == n[0])));
            accept[n]   = rd_vec[n] && !drop_vec[n];
            pend_nxt[n] = accept[n] || (pend[n] && !done_vec[n]);
        end

        case (state)
            ST_IDLE:  if (fetch_now)   state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (fr_complete) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    assign done0 = done_vec[0];
    assign done1 = done_vec[1];
    assign drop  = |drop_vec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            pend       <= 2'b00;
            last_grant <= 1'b1;
            fr_rd      <= 1'b0;
            fr_addr    <= '0;
        end else begin
            state <= state_nxt;
            pend  <= pend_nxt;
            fr_rd <= fetch_now;
            if (fetch_now) begin
                fr_addr <= ADDR_WIDTH'(line_align(MAX_ADDR_W'(padd_sel), LINE_OFF_W));
            end
            if (fetch_now || hit_now) begin
                last_grant <= g_sel;
            end
        end
    end

    // Request addresses carry no reset; they are meaningful only while pend is set.
    always_ff @(posedge clk) begin
        if (accept[0]) padd0 <= addr0;
        if (accept[1]) padd1 <= addr1;
    end

endmodule

// File: tb/tb_flash_reader_arb.sv
// Directed bench for flash_reader_arb with a behavioural flash reader (40-cycle latency)
// and a second fixed-priority instance; buffer checks run when FLASH_ARB_LINE_BUF_EN is defined.
module tb_flash_reader_arb;
    import flash_arb_pkg::*;

    localparam int LS = 128;
    localparam int AW = 24;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rd0 = 1'b0, rd1 = 1'b0, buf_inv = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic          done0, done1, busy, drop, fr_rd;
    logic [LS-1:0] line, fr_line;
    logic [AW-1:0] fr_addr;
    logic          fr_done;

    logic          rd0_kick = 1'b0, rd1_fp = 1'b0, auto0 = 1'b0;
    logic          rd0_fp;
    logic          done0_fp, done1_fp, busy_fp, drop_fp, fr_rd_fp, fr_done_fp;
    logic [LS-1:0] line_fp, fr_line_fp;
    logic [AW-1:0] fr_addr_fp;

    int n_chk = 0, n_err = 0;
    int n_done0 = 0, n_done1 = 0, n_drop = 0, n_frrd = 0, n_done0_fp = 0, n_done1_fp = 0;
    int overlap = 0, cnt = 0, cnt_fp = 0;
    bit spur = 1'b0;
    logic [LS-1:0] last_line0 = '0, last_line1 = '0;
    logic [AW-1:0] last_fr_addr = '0, m_addr = '0;
    int s_d0, s_d1, s_drop, s_frrd;

    always #5 clk = ~clk;

    assign rd0_fp = rd0_kick | (auto0 & done0_fp);

    flash_reader_arb #(.LINE_SIZE(LS), .ADDR_WIDTH(AW), .FIXED_PRIO(1'b0)) dut (
        .clk(clk), .rst(rst), .rd0(rd0), .rd1(rd1), .addr0(addr0), .addr1(addr1),
        .done0(done0), .done1(done1), .line(line), .busy(busy), .drop(drop),
        .buf_inv(buf_inv), .fr_addr(fr_addr), .fr_rd(fr_rd), .fr_done(fr_done), .fr_line(fr_line)
    );

    flash_reader_arb #(.LINE_SIZE(LS), .ADDR_WIDTH(AW), .FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .rst(rst), .rd0(rd0_fp), .rd1(rd1_fp), .addr0(24'h000100), .addr1(24'h000200),
        .done0(done0_fp), .done1(done1_fp), .line(line_fp), .busy(busy_fp), .drop(drop_fp),
        .buf_inv(1'b0), .fr_addr(fr_addr_fp), .fr_rd(fr_rd_fp), .fr_done(fr_done_fp),
        .fr_line(fr_line_fp)
    );

    function automatic logic [LS-1:0] pat(input logic [AW-1:0] a);
        return {4{8'hA5, a}};
    endfunction

    task automatic chk(input string tag, input logic [LS-1:0] got, input logic [LS-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic p0, input logic p1, input logic [AW-1:0] a0,
                         input logic [AW-1:0] a1);
        rd0 = p0; rd1 = p1; addr0 = a0; addr1 = a1;
        @(negedge clk);
        rd0 = 1'b0; rd1 = 1'b0;
    endtask

    task automatic snap();
        s_d0 = n_done0; s_d1 = n_done1; s_drop = n_drop; s_frrd = n_frrd;
    endtask

    // Reader model for the main instance: done 40 cycles after fr_rd, shares rst.
    initial begin
        fr_done = 1'b0; fr_line = '0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                cnt = 0; fr_done = 1'b0;
            end else if (spur) begin
                fr_done = 1'b1; fr_line = pat(24'hDEAD00); spur = 1'b0;
            end else if (fr_done) begin
                fr_done = 1'b0;
            end else if (fr_rd) begin
                if (cnt != 0) overlap++;
                cnt = 40; m_addr = fr_addr;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin fr_done = 1'b1; fr_line = pat(m_addr); end
            end
        end
    end

    initial begin
        fr_done_fp = 1'b0; fr_line_fp = '0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                cnt_fp = 0; fr_done_fp = 1'b0;
            end else if (fr_done_fp) begin
                fr_done_fp = 1'b0;
            end else if (fr_rd_fp) begin
                cnt_fp = 3;
            end else if (cnt_fp > 0) begin
                cnt_fp--;
                if (cnt_fp == 0) begin fr_done_fp = 1'b1; fr_line_fp = pat(fr_addr_fp); end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk); #2;
            if (done0) begin n_done0++; last_line0 = line; end
            if (done1) begin n_done1++; last_line1 = line; end
            if (drop) n_drop++;
            if (fr_rd) begin n_frrd++; last_fr_addr = fr_addr; end
            if (done0_fp) n_done0_fp++;
            if (done1_fp) n_done1_fp++;
        end
    end

    initial begin
        cyc(3);
        rst = 1'b0;
        cyc(1);
        chk("rst_busy", LS'(busy), LS'(0));
        chk("rst_fr_rd", LS'(fr_rd), LS'(0));
        chk("rst_fr_addr", LS'(fr_addr), LS'(0));
        chk("rst_done", LS'({done1, done0, drop}), LS'(0));
        chk("rst_line", line, LS'(0));
        chk("rst_pend", LS'(dut.pend), LS'(0));
        chk("rst_last_grant", LS'(dut.last_grant), LS'(1));

        // Fixed priority: port 0 re-requests on every done0, so port 1 starves.
        rd0_kick = 1'b1; rd1_fp = 1'b1; auto0 = 1'b1;
        @(negedge clk);
        rd0_kick = 1'b0; rd1_fp = 1'b0;
        cyc(60);
        chk("fp_starve_done1", LS'(n_done1_fp), LS'(0));
        chk("fp_port0_served", LS'(n_done0_fp >= 5), LS'(1));
        auto0 = 1'b0;
        cyc(20);
        chk("fp_port1_after", LS'(n_done1_fp), LS'(1));

        // Simultaneous requests, round-robin: port 0 first after reset.
        snap();
        pulse(1'b1, 1'b1, 24'h000100, 24'h000200);
        cyc(44);
        chk("rr_first_done0", LS'(n_done0 - s_d0), LS'(1));
        chk("rr_first_done1", LS'(n_done1 - s_d1), LS'(0));
        chk("rr_first_line", last_line0, pat(24'h000100));
        chk("rr_second_addr", LS'(fr_addr), LS'(24'h000200));
        cyc(46);
        chk("rr_second_done1", LS'(n_done1 - s_d1), LS'(1));
        chk("rr_second_line", last_line1, pat(24'h000200));
        chk("rr_frrd_count", LS'(n_frrd - s_frrd), LS'(2));
        chk("rr_no_overlap", LS'(overlap), LS'(0));

        // Single fetch: latency and line alignment.
        snap();
        pulse(1'b1, 1'b0, 24'h001234, 24'h0);
        cyc(1);
        chk("lat_fr_rd_high", LS'(fr_rd), LS'(1));
        chk("lat_fr_addr", LS'(fr_addr), LS'(24'h001230));
        chk("lat_busy", LS'(busy), LS'(1));
        cyc(1);
        chk("lat_fr_rd_pulse", LS'(fr_rd), LS'(0));
        cyc(45);
        chk("single_done0", LS'(n_done0 - s_d0), LS'(1));
        chk("single_done1", LS'(n_done1 - s_d1), LS'(0));
        chk("single_frrd", LS'(n_frrd - s_frrd), LS'(1));
        chk("single_line", last_line0, pat(24'h001230));
        chk("single_idle", LS'(busy), LS'(0));

        // Re-request by the owner while its fetch is in flight is dropped.
        snap();
        pulse(1'b1, 1'b0, 24'h000300, 24'h0);
        cyc(5);
        pulse(1'b1, 1'b0, 24'h000340, 24'h0);
        cyc(45);
        chk("drop_count", LS'(n_drop - s_drop), LS'(1));
        chk("drop_done0", LS'(n_done0 - s_d0), LS'(1));
        chk("drop_frrd", LS'(n_frrd - s_frrd), LS'(1));
        chk("drop_addr", LS'(last_fr_addr), LS'(24'h000300));
        chk("drop_pend", LS'(dut.pend), LS'(0));

        // Reset ten cycles into the wait state.
        snap();
        pulse(1'b1, 1'b0, 24'h000400, 24'h0);
        cyc(12);
        chk("midrst_in_wait", LS'(dut.state), LS'(ST_WAIT));
        rst = 1'b1;
        #1;
        chk("midrst_state", LS'(dut.state), LS'(ST_IDLE));
        chk("midrst_busy", LS'(busy), LS'(0));
        chk("midrst_pend", LS'(dut.pend), LS'(0));
        chk("midrst_fr_rd", LS'(fr_rd), LS'(0));
        cyc(2);
        rst = 1'b0;
        cyc(1);
        pulse(1'b0, 1'b1, 24'h0, 24'h000567);
        cyc(45);
        chk("midrst_fresh_done1", LS'(n_done1 - s_d1), LS'(1));
        chk("midrst_no_done0", LS'(n_done0 - s_d0), LS'(0));
        chk("midrst_fresh_line", last_line1, pat(24'h000560));

        // Spurious fr_done while idle.
        snap();
        spur = 1'b1;
        cyc(3);
        chk("spur_done", LS'((n_done0 - s_d0) + (n_done1 - s_d1)), LS'(0));
        chk("spur_pend", LS'(dut.pend), LS'(0));
        chk("spur_state", LS'(dut.state), LS'(ST_IDLE));
        chk("spur_frrd", LS'(n_frrd - s_frrd), LS'(0));

`ifdef FLASH_ARB_LINE_BUF_EN
        snap();
        pulse(1'b1, 1'b0, 24'h000040, 24'h0);
        cyc(45);
        chk("buf_fill_done0", LS'(n_done0 - s_d0), LS'(1));
        snap();
        pulse(1'b0, 1'b1, 24'h0, 24'h00004C);
        cyc(2);
        chk("buf_hit_done1", LS'(n_done1 - s_d1), LS'(1));
        chk("buf_hit_no_frrd", LS'(n_frrd - s_frrd), LS'(0));
        chk("buf_hit_line", last_line1, pat(24'h000040));
        chk("buf_hit_idle", LS'(busy), LS'(0));
        buf_inv = 1'b1;
        cyc(1);
        buf_inv = 1'b0;
        snap();
        pulse(1'b0, 1'b1, 24'h0, 24'h00004C);
        cyc(45);
        chk("buf_inv_frrd", LS'(n_frrd - s_frrd), LS'(1));
        chk("buf_inv_addr", LS'(last_fr_addr), LS'(24'h000040));
        chk("buf_inv_done1", LS'(n_done1 - s_d1), LS'(1));
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
